// File: rtl/descriptor_arbiter.sv
// descriptor_arbiter
//   Round-robin arbiter that shares one downstream descriptor write
//   interface among 4 per-port descriptor senders. Each requester holds a
//   level write until it is acked. The arbiter grants one port, forwards
//   its descriptor, and routes the downstream ack back to that port only.
//   A watchdog aborts a transaction that is never acked, so an input port
//   cannot hang.
//
// Ports
//   clk_sys, reset_n        system clock, asynchronous active-low reset
//   iv_descriptor_wr[3:0]   per-port level write request (bit i = port i)
//   iv_descriptor0..3       per-port descriptor, stable while its wr is high
//   ov_descriptor_ack[3:0]  one-cycle ack pulse to the granted port
//   o_descriptor_wr         downstream write, held until ack or abort
//   ov_descriptor           forwarded descriptor (0 while o_descriptor_wr=0)
//   ov_src_port             port index of the forwarded descriptor
//   i_descriptor_ack        downstream ack pulse
//   o_timeout_pulse         one-cycle pulse on watchdog abort
//   ov_timeout_cnt          saturating abort counter
//   arbiter_state           FSM state, for debug
module descriptor_arbiter #(
    parameter int DESC_WIDTH     = 72,
    parameter int TIMEOUT_CYCLES = 1024   // 0 disables the watchdog
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [3:0]            iv_descriptor_wr,
    input  logic [DESC_WIDTH-1:0] iv_descriptor0,
    input  logic [DESC_WIDTH-1:0] iv_descriptor1,
    input  logic [DESC_WIDTH-1:0] iv_descriptor2,
    input  logic [DESC_WIDTH-1:0] iv_descriptor3,
    output logic [3:0]            ov_descriptor_ack,
    output logic                  o_descriptor_wr,
    output logic [DESC_WIDTH-1:0] ov_descriptor,
    output logic [1:0]            ov_src_port,
    input  logic                  i_descriptor_ack,
    output logic                  o_timeout_pulse,
    output logic [15:0]           ov_timeout_cnt,
    output logic [1:0]            arbiter_state
);

    localparam int NUM_PORTS = 4;
    localparam int WD_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_ACK = 2'b01,
        RELEASE  = 2'b10,
        ILLEGAL  = 2'b11
    } state_t;

    state_t                                 state, state_d;
    logic [1:0]                             ptr, ptr_d;
    logic [WD_W-1:0]                        wdog, wdog_d;
    logic [NUM_PORTS-1:0][DESC_WIDTH-1:0]   desc_arr;
    logic [1:0]                             grant;
    logic                                   grant_vld;
    logic                                   wd_expire;

    logic                  wr_d;
    logic [DESC_WIDTH-1:0] desc_d;
    logic [1:0]            src_d;
    logic [3:0]            ack_d;
    logic                  to_d;
    logic [15:0]           cnt_d;

    assign desc_arr[0]   = iv_descriptor0;
    assign desc_arr[1]   = iv_descriptor1;
    assign desc_arr[2]   = iv_descriptor2;
    assign desc_arr[3]   = iv_descriptor3;
    assign arbiter_state = state;

    // Rotating priority: scan from the highest offset down so the port
    // closest to ptr is the last (winning) assignment.
    always_comb begin
        grant_vld = 1'b0;
        grant     = 2'd0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (iv_descriptor_wr[ptr + 2'(i)]) begin
                grant_vld = 1'b1;
                grant     = ptr + 2'(i);
            end
        end
    end

    // wdog counts completed WAIT_ACK cycles, so it sits at TIMEOUT_CYCLES-1
    // during the last cycle the write may stay up.
    assign wd_expire = (TIMEOUT_CYCLES > 0) && (wdog == WD_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        wdog_d  = wdog;
        wr_d    = o_descriptor_wr;
        desc_d  = ov_descriptor;
        src_d   = ov_src_port;
        ack_d   = '0;
        to_d    = 1'b0;
        cnt_d   = ov_timeout_cnt;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    wr_d    = 1'b1;
                    desc_d  = desc_arr[grant];
                    src_d   = grant;
                    ptr_d   = grant + 2'd1;
                    wdog_d  = '0;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (i_descriptor_ack || wd_expire) begin
                    wr_d    = 1'b0;
                    desc_d  = '0;
                    src_d   = '0;
                    ack_d   = 4'b0001 << ov_src_port;
                    wdog_d  = '0;
                    state_d = RELEASE;
                    // A real ack in the expiry cycle is a normal completion.
                    if (!i_descriptor_ack) begin
                        to_d = 1'b1;
                        if (ov_timeout_cnt != 16'hFFFF)
                            cnt_d = ov_timeout_cnt + 16'd1;
                    end
                end else begin
                    wdog_d = wdog + WD_W'(1);
                end
            end
            // One-cycle bubble: the released requester drops wr before the
            // next arbitration, so a stale request is never re-granted.
            RELEASE: state_d = IDLE;
            default: begin
                state_d = IDLE;
                wr_d    = 1'b0;
                desc_d  = '0;
                src_d   = '0;
                cnt_d   = '0;
                wdog_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            ptr               <= '0;
            wdog              <= '0;
            o_descriptor_wr   <= 1'b0;
            ov_descriptor     <= '0;
            ov_src_port       <= '0;
            ov_descriptor_ack <= '0;
            o_timeout_pulse   <= 1'b0;
            ov_timeout_cnt    <= '0;
        end else begin
            state             <= state_d;
            ptr               <= ptr_d;
            wdog              <= wdog_d;
            o_descriptor_wr   <= wr_d;
            ov_descriptor     <= desc_d;
            ov_src_port       <= src_d;
            ov_descriptor_ack <= ack_d;
            o_timeout_pulse   <= to_d;
            ov_timeout_cnt    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_descriptor_arbiter.sv
// tb_descriptor_arbiter
//   Self-checking bench for descriptor_arbiter (TIMEOUT_CYCLES=8). A
//   transaction-level reference model keeps the round-robin pointer, the
//   requesters' wr mask and the expected abort count; every transaction is
//   checked cycle by cycle against that model. Directed sections cover the
//   single-request, fairness, pointer-wrap, watchdog, ack/timeout tie and
//   mid-transaction reset cases, followed by randomized traffic.
module tb_descriptor_arbiter;

    localparam int DW = 72;
    localparam int TO = 8;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic [3:0]    req     = 4'b0;
    logic          ack_in  = 1'b0;
    logic [DW-1:0] desc_m [4];

    logic [3:0]    ov_descriptor_ack;
    logic          o_descriptor_wr;
    logic [DW-1:0] ov_descriptor;
    logic [1:0]    ov_src_port;
    logic          o_timeout_pulse;
    logic [15:0]   ov_timeout_cnt;
    logic [1:0]    arbiter_state;

    int n_chk  = 0;
    int n_pass = 0;
    int ptr_m  = 0;
    int cnt_m  = 0;

    always #5 clk_sys = ~clk_sys;

    descriptor_arbiter #(.DESC_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_sys           (clk_sys),
        .reset_n           (reset_n),
        .iv_descriptor_wr  (req),
        .iv_descriptor0    (desc_m[0]),
        .iv_descriptor1    (desc_m[1]),
        .iv_descriptor2    (desc_m[2]),
        .iv_descriptor3    (desc_m[3]),
        .ov_descriptor_ack (ov_descriptor_ack),
        .o_descriptor_wr   (o_descriptor_wr),
        .ov_descriptor     (ov_descriptor),
        .ov_src_port       (ov_src_port),
        .i_descriptor_ack  (ack_in),
        .o_timeout_pulse   (o_timeout_pulse),
        .ov_timeout_cnt    (ov_timeout_cnt),
        .arbiter_state     (arbiter_state)
    );

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // First requesting port at or after the pointer, wrapping mod 4.
    function automatic int model_grant();
        for (int i = 0; i < 4; i++)
            if (req[(ptr_m + i) % 4]) return (ptr_m + i) % 4;
        return -1;
    endfunction

    function automatic logic [DW-1:0] rnd_desc();
        return {8'($urandom), $urandom, $urandom};
    endfunction

    // Raise wr on port p with a fresh descriptor (only if it was idle).
    task automatic raise(input int p);
        if (!req[p]) begin
            desc_m[p] = rnd_desc();
            req[p]    = 1'b1;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_wr"},    DW'(o_descriptor_wr),   DW'(0));
        chk({tag, "_desc"},  ov_descriptor,          DW'(0));
        chk({tag, "_src"},   DW'(ov_src_port),       DW'(0));
        chk({tag, "_ack"},   DW'(ov_descriptor_ack), DW'(0));
        chk({tag, "_tpls"},  DW'(o_timeout_pulse),   DW'(0));
        chk({tag, "_cnt"},   DW'(ov_timeout_cnt),    DW'(cnt_m));
        chk({tag, "_state"}, DW'(arbiter_state),     DW'(0));
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req     = 4'b0;
        ack_in  = 1'b0;
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        ptr_m   = 0;
        cnt_m   = 0;
        @(negedge clk_sys);
        check_idle_outputs("rst");
    endtask

    // Entered at a negedge in IDLE with req nonzero. d = cycles the ack is
    // delayed after o_descriptor_wr rises; d >= TO means the watchdog fires.
    // spur drives a stray ack in the IDLE and RELEASE cycles.
    task automatic do_txn(input int d, input bit spur);
        int            g, n;
        bit            to;
        logic [DW-1:0] exp_desc;
        logic [3:0]    exp_ack;
        g        = model_grant();
        exp_desc = desc_m[g];
        n        = (d < TO) ? d + 1 : TO;
        to       = (d >= TO);
        ack_in   = spur;
        @(negedge clk_sys);
        ack_in = 1'b0;
        for (int k = 1; k <= n; k++) begin
            if (k > 1) @(negedge clk_sys);
            if (k == 1) begin
                chk("grant_src", DW'(ov_src_port),   DW'(g));
                chk("wait_state", DW'(arbiter_state), DW'(1));
            end
            chk("wait_wr",   DW'(o_descriptor_wr),   DW'(1));
            chk("wait_desc", ov_descriptor,          exp_desc);
            chk("wait_ack",  DW'(ov_descriptor_ack), DW'(0));
            if (k == n && !to) ack_in = 1'b1;
        end
        @(negedge clk_sys);
        ack_in = spur;
        if (to && cnt_m < 65535) cnt_m++;
        exp_ack = 4'(1 << g);
        chk("rel_ack",   DW'(ov_descriptor_ack), DW'(exp_ack));
        chk("rel_tpls",  DW'(o_timeout_pulse),   DW'(to));
        chk("rel_cnt",   DW'(ov_timeout_cnt),    DW'(cnt_m));
        chk("rel_wr",    DW'(o_descriptor_wr),   DW'(0));
        chk("rel_desc",  ov_descriptor,          DW'(0));
        chk("rel_src",   DW'(ov_src_port),       DW'(0));
        chk("rel_state", DW'(arbiter_state),     DW'(2));
        req[g] = 1'b0;
        ptr_m  = (g + 1) % 4;
        @(negedge clk_sys);
        ack_in = 1'b0;
        check_idle_outputs("idle");
    endtask

    initial begin
        for (int i = 0; i < 4; i++) desc_m[i] = '0;
        repeat (2) @(negedge clk_sys);
        check_idle_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk_sys);
        check_idle_outputs("post_reset");

        // Single request on port 2, ack 3 cycles after the write rises.
        desc_m[2] = 72'hAB_0000_0000_0000_0123;
        req       = 4'b0100;
        do_txn(3, 1'b0);

        // Pointer is now 3: ports 0 and 3 requesting -> 3 then 0.
        raise(0);
        raise(3);
        do_txn(2, 1'b0);
        do_txn(1, 1'b0);

        // Fairness from reset: all four continuously requesting.
        apply_reset();
        for (int t = 0; t < 5; t++) begin
            for (int p = 0; p < 4; p++) raise(p);
            do_txn(0, 1'b0);
        end

        // Watchdog: three aborts in a row.
        apply_reset();
        for (int t = 0; t < 3; t++) begin
            raise(0);
            do_txn(20, 1'b0);
        end

        // Ack in the same cycle the watchdog would expire.
        raise(1);
        do_txn(TO - 1, 1'b0);

        // Reset during WAIT_ACK with port 1 granted; port 3 joins meanwhile.
        raise(1);
        @(negedge clk_sys);
        chk("pre_rst_wr",  DW'(o_descriptor_wr), DW'(1));
        chk("pre_rst_src", DW'(ov_src_port),     DW'(1));
        raise(3);
        @(negedge clk_sys);
        reset_n = 1'b0;
        #1;
        ptr_m = 0;
        cnt_m = 0;
        check_idle_outputs("async_rst");
        @(negedge clk_sys);
        reset_n = 1'b1;
        do_txn(2, 1'b1);
        do_txn(0, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            int nb;
            nb = $urandom_range(0, 15);
            for (int p = 0; p < 4; p++) if (nb[p]) raise(p);
            if (req == 4'b0) raise($urandom_range(0, 3));
            do_txn($urandom_range(0, 10), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/descriptor_arbiter.md
Name: descriptor_arbiter

Overview:
- Round-robin arbiter sharing one downstream descriptor write interface (lookup/queue-manager side) among 4 per-port descriptor senders in network_input_process.
- Each requester holds a level descriptor write until acked; the arbiter grants one, forwards its descriptor, and returns the downstream ack to the granted requester only.
- A watchdog releases a requester whose descriptor is never acked, so an input port cannot hang.

Parameters:
- DESC_WIDTH, 72, descriptor width.
- TIMEOUT_CYCLES, 1024, WAIT_ACK cycles before abort; 0 disables the watchdog.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  reset.
- iv_descriptor_wr  in  4  per-port level write request; bit i = port i.
- iv_descriptor0..iv_descriptor3  in  DESC_WIDTH each  per-port descriptor, stable while its wr is high.
- ov_descriptor_ack  out  4  one-cycle ack pulse to the granted port.
- o_descriptor_wr  out  1  downstream write, level, held until ack or abort.
- ov_descriptor  out  DESC_WIDTH  forwarded descriptor.
- ov_src_port  out  2  port index of the forwarded descriptor.
- i_descriptor_ack  in  1  downstream ack pulse.
- o_timeout_pulse  out  1  one-cycle pulse on watchdog abort.
- ov_timeout_cnt  out  16  saturating abort counter.
- arbiter_state  out  2  FSM state (debug).

Behaviour:
- Reset: reset_n, asynchronous, active-low; clock clk_sys.
- Reset values: all outputs 0, arbiter_state=IDLE(2'b00), RR pointer=0, watchdog counter=0.
- States: IDLE=2'b00, WAIT_ACK=2'b01, RELEASE=2'b10; 2'b11 returns to IDLE with all outputs cleared.
- IDLE: if any iv_descriptor_wr bit is set, grant the first set bit searching pointer, pointer+1, ... (mod 4).
  - Next cycle: o_descriptor_wr=1, ov_descriptor = granted port's descriptor (registered), ov_src_port = grant.
  - Pointer becomes grant+1 mod 4; state goes to WAIT_ACK.
  - Latency from sampled request to o_descriptor_wr is 1 cycle.
- WAIT_ACK: o_descriptor_wr, ov_descriptor and ov_src_port are held stable. The watchdog increments each cycle.
  - On i_descriptor_ack=1: clear o_descriptor_wr, ov_descriptor and ov_src_port. Pulse ov_descriptor_ack[grant] for 1 cycle. Clear the watchdog. Go to RELEASE.
  - If TIMEOUT_CYCLES>0 and the watchdog reaches TIMEOUT_CYCLES without an ack: same actions as an ack. Additionally pulse o_timeout_pulse and increment ov_timeout_cnt, saturating at 16'hFFFF.
  - Ack and timeout in the same cycle: the ack wins; no timeout pulse, no count.
- RELEASE: ov_descriptor_ack=0; go to IDLE. This bubble guarantees the released requester has dropped its wr before the next arbitration, so no re-grant of a stale request.
- i_descriptor_ack in IDLE or RELEASE is ignored.
- Request changes outside the granted port do not affect the current transaction.
- Throughput: one descriptor per (ack latency + 3) cycles.
- Fairness: with all 4 requesting continuously, grants are 0,1,2,3,0,...
- ov_descriptor is 0 whenever o_descriptor_wr=0.
- Reset mid-transaction: everything clears immediately and the pointer returns to 0. Requesters still holding wr are re-arbitrated after reset is released.

Test Plan:
- Single request: iv_descriptor_wr=4'b0100, iv_descriptor2=72'hAB_0000_0000_0000_0123; ack 3 cycles after o_descriptor_wr.
  - Expect o_descriptor_wr 1 cycle after the request, ov_descriptor=72'hAB_0000_0000_0000_0123 and ov_src_port=2.
  - Expect ov_descriptor_ack=4'b0100 for exactly 1 cycle the cycle after the ack, then IDLE.
- All four ports requesting from reset, each released on ack (immediate ack) -> grant order 0,1,2,3,0; ov_src_port follows that order; no port is granted twice in a row while others wait.
- Pointer wrap: pointer=3 after a grant to port 2; requests on ports 0 and 3 -> port 3 granted first, then port 0.
- Watchdog: TIMEOUT_CYCLES=8, no ack.
  - Expect o_descriptor_wr held for 8 cycles, then dropped.
  - Expect o_timeout_pulse=1 and ov_descriptor_ack pulsed for 1 cycle, ov_timeout_cnt=1.
  - Repeat 3 times -> ov_timeout_cnt=3.
- Ack on the same cycle as timeout expiry: TIMEOUT_CYCLES=8, ack on the 8th WAIT_ACK cycle -> no o_timeout_pulse, ov_timeout_cnt unchanged, normal release.
- Reset asserted during WAIT_ACK with port 1 granted -> all outputs 0 asynchronously. After release, with port 1 wr still high, it is re-granted via pointer 0 search; spurious ack pulses in IDLE are ignored.
